// File: rtl/fifo_enq_arbiter.sv
// ============================================================================
// Module   : fifo_enq_arbiter
// Purpose  : Packet-locked round-robin arbiter and flush sequencer for a FIFO enqueue port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_enq_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_SIZE    = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data_i,
  input  logic [N_REQ-1:0]           req_last_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [DATA_SIZE-1:0]       enq_data_o,
  output logic                       enq_valid_o,
  input  logic                       enq_ready_i,
  input  logic                       flush_req_i,
  output logic                       fifo_flush_o,
  output logic                       flush_done_o,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       busy_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_SIZE-1:0] w_data_arr [N_REQ];
  logic                 w_arb_found;
  logic [PTR_W-1:0]     w_arb_idx;
  logic [PTR_W-1:0]     w_g;
  logic                 w_gvld;
  logic                 w_xfer;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = req_data_i[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  // Scan offsets high to low so the last hit is the one closest to rr_ptr.
  always_comb begin
    int s;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    s           = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (req_valid_i[PTR_W'(s)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = PTR_W'(s);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gidx_d       = gidx_q;
    cnt_d        = cnt_q;
    w_g          = gidx_q;
    w_gvld       = 1'b0;
    fifo_flush_o = 1'b0;
    flush_done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_req_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (w_arb_found) begin
          w_g    = w_arb_idx;
          w_gvld = 1'b1;
        end
      end
      S_LOCKED: w_gvld = 1'b1;
      S_FLUSH: begin
        fifo_flush_o = 1'b1;
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) state_d = S_DONE;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        flush_done_o = 1'b1;
        rr_ptr_d     = '0;
        state_d      = S_IDLE;
      end
    endcase

    enq_valid_o = w_gvld && req_valid_i[w_g];
    enq_data_o  = w_gvld ? w_data_arr[w_g] : '0;
    grant_o     = w_gvld ? (N_REQ'(1) << w_g) : '0;
    req_ready_o = enq_ready_i ? grant_o : '0;
    w_xfer      = enq_valid_o && enq_ready_i;

    if (w_xfer) begin
      if (req_last_i[w_g]) begin
        rr_ptr_d = f_next(w_g);
        if (state_q == S_LOCKED) begin
          // A pending flush is honoured only once the packet has ended.
          state_d = flush_req_i ? S_FLUSH : S_IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = S_LOCKED;
        gidx_d  = w_g;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_enq_arbiter.sv
// ============================================================================
// Module   : tb_fifo_enq_arbiter
// Purpose  : Directed and random checking of fifo_enq_arbiter against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_enq_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FC = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [DW-1:0]   dat [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   enq_data;
  logic            enq_valid;
  logic            enq_ready;
  logic            flush_req;
  logic            fifo_flush;
  logic            flush_done;
  logic [N-1:0]    grant;
  logic            busy;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  fifo_enq_arbiter #(.N_REQ(N), .DATA_SIZE(DW), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .enq_data_o   (enq_data),
    .enq_valid_o  (enq_valid),
    .enq_ready_i  (enq_ready),
    .flush_req_i  (flush_req),
    .fifo_flush_o (fifo_flush),
    .flush_done_o (flush_done),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner of the current packet, next priority, flush progress.
  int m_owner;
  int m_ptr;
  int m_flush_left;
  bit m_done;

  logic [N-1:0]  e_grant, e_rr;
  logic [DW-1:0] e_data;
  logic          e_ev, e_ff, e_fd, e_busy, e_xfer;
  int            e_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_flush_left = 0; m_done = 0;
  endtask

  task automatic eval_and_check();
    bit found;
    #1;
    e_g = -1; e_ff = 0; e_fd = 0; e_busy = 1;
    if (m_done)                e_fd = 1;
    else if (m_flush_left > 0) e_ff = 1;
    else if (m_owner >= 0)     e_g  = m_owner;
    else begin
      e_busy = 0;
      found  = 0;
      if (!flush_req)
        for (int k = 0; k < N; k++)
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1;
            e_g   = (m_ptr + k) % N;
          end
    end
    e_grant = (e_g >= 0) ? N'(1 << e_g) : '0;
    e_ev    = (e_g >= 0) && req_valid[e_g];
    e_data  = (e_g >= 0) ? dat[e_g] : '0;
    e_rr    = enq_ready ? e_grant : '0;
    e_xfer  = e_ev && enq_ready;
    chk("grant",      grant,      e_grant);
    chk("enq_valid",  enq_valid,  e_ev);
    chk("enq_data",   enq_data,   e_data);
    chk("req_ready",  req_ready,  e_rr);
    chk("fifo_flush", fifo_flush, e_ff);
    chk("flush_done", flush_done, e_fd);
    chk("busy",       busy,       e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (m_done) begin
      m_done = 0; m_ptr = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_done = 1;
    end else if (m_owner >= 0) begin
      if (e_xfer && req_last[e_g]) begin
        m_ptr   = (e_g + 1) % N;
        m_owner = -1;
        if (flush_req) m_flush_left = FC;
      end
    end else if (flush_req) m_flush_left = FC;
    else if (e_xfer) begin
      if (req_last[e_g]) m_ptr = (e_g + 1) % N;
      else               m_owner = e_g;
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) dat[i] = $urandom;
  endtask

  // Lets a flush run to completion, releasing flush_req in the done cycle.
  task automatic finish_flush();
    bit was_done;
    for (int c = 0; c < 10; c++) begin
      was_done = m_done;
      if (m_done) flush_req = 0;
      eval_and_check();
      tick();
      if (was_done) break;
    end
  endtask

  initial begin
    rst = 1; req_valid = '0; req_last = '0; enq_ready = 1; flush_req = 0;
    rand_data();
    model_reset();
    @(posedge clk); #1;
    tick();
    rst = 0;

    // Reset state
    eval_and_check();
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    tick();

    // Round robin, single-beat packets
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      eval_and_check();
      chk("rr_order", grant, 4'b0001 << (k % 4));
      tick();
    end

    // Move pointer to 0 with a req3 beat, then req0 3-beat packet vs req1
    req_valid = 4'b1000;
    eval_and_check();
    tick();
    req_valid = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b0011 : 4'b0010;
      rand_data();
      eval_and_check();
      chk("pkt_grant0", grant, 4'b0001);
      chk("pkt_block1", req_ready[1], 0);
      tick();
    end
    eval_and_check();
    chk("pkt_then1", grant, 4'b0010);
    tick();

    // Stall mid-packet on req2
    req_valid = 4'b0100; req_last = 4'b0000;
    eval_and_check();
    tick();
    enq_ready = 0;
    for (int c = 0; c < 5; c++) begin
      eval_and_check();
      chk("stall_grant", grant, 4'b0100);
      chk("stall_ready", req_ready, 0);
      chk("stall_data", enq_data, dat[2]);
      tick();
    end
    enq_ready = 1; req_last = 4'b0100;
    eval_and_check();
    chk("stall_resume", req_ready, 4'b0100);
    tick();

    // Flush requested during a 4-beat packet from req1
    req_valid = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      req_last = (b == 3) ? 4'b0010 : 4'b0000;
      if (b == 1) flush_req = 1;
      rand_data();
      eval_and_check();
      chk("flush_wait_grant", grant, 4'b0010);
      chk("flush_wait_ff", fifo_flush, 0);
      tick();
    end
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < FC; c++) begin
      eval_and_check();
      chk("flush_hold", fifo_flush, 1);
      tick();
    end
    flush_req = 0;
    eval_and_check();
    chk("flush_done", flush_done, 1);
    tick();
    eval_and_check();
    chk("ptr_cleared", grant, 4'b0001);
    tick();

    // Flush and request collide in IDLE
    req_valid = 4'b0100; req_last = 4'b0100; flush_req = 1;
    eval_and_check();
    chk("coll_grant", grant, 0);
    chk("coll_valid", enq_valid, 0);
    tick();
    eval_and_check();
    chk("coll_flush", fifo_flush, 1);
    tick();
    finish_flush();

    // Reset while locked
    req_valid = 4'b0001; req_last = 4'b0000;
    eval_and_check(); tick();
    eval_and_check(); tick();
    rst = 1; req_valid = '0;
    eval_and_check(); tick();
    rst = 0;
    eval_and_check();
    chk("rstlk_grant", grant, 0);
    chk("rstlk_valid", enq_valid, 0);
    tick();
    req_valid = 4'b1000; req_last = 4'b1000;
    eval_and_check();
    chk("rstlk_req3", grant, 4'b1000);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom) & N'($urandom);
      enq_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      if (!flush_req && $urandom_range(0, 39) == 0) flush_req = 1;
      else if (flush_req && m_done && $urandom_range(0, 3) != 0) flush_req = 0;
      rst = ($urandom_range(0, 149) == 0);
      eval_and_check();
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
